// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, frame geometry
// and the FIFO occupancy-count width helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

    // Bits captured after the start bit: D0..D7, parity, stop.
    localparam int FRAME_BITS = 10;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is refused
// unless a pop happens in the same cycle; a pop while empty is ignored.
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Head reads as zero while empty so the output is defined out of reset.
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the pins,
// deframes 11-bit frames, checks them and buffers good bytes in a FIFO.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overflow
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BCNT_W = $clog2(FRAME_BITS + 1);

    logic [1:0]            clk_sync_q;
    logic [1:0]            data_sync_q;
    logic                  clk_filt_q;
    logic                  fall_q;
    logic [FILT_W-1:0]     filt_cnt_q;
    ps2_state_e            state_q;
    logic [BCNT_W-1:0]     bit_cnt_q;
    logic [FRAME_BITS-1:0] sr_q;
    logic [WDOG_W-1:0]     wdog_q;
    logic                  frame_err_q;
    logic                  overflow_q;

    logic data_bit;
    logic frame_ok;
    logic push;
    logic err_set;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_drop;

    assign data_bit = data_sync_q[1];

    // The filtered clock flips only after FILTER_LEN consecutive samples that
    // disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            fall_q      <= 1'b0;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            fall_q      <= 1'b0;
            if (clk_sync_q[1] == clk_filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                clk_filt_q <= clk_sync_q[1];
                filt_cnt_q <= '0;
                fall_q     <= clk_filt_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // sr_q holds D0..D7 in [7:0], parity in [8], stop in [9].
    assign frame_ok = (^sr_q[8:0]) && sr_q[9];
    assign push     = (state_q == CHECK) && frame_ok;
    assign err_set  = ((state_q == IDLE)  && fall_q && data_bit)
                   || ((state_q == CHECK) && !frame_ok)
                   || ((state_q == SHIFT) && !fall_q && (wdog_q == WDOG_W'(TIMEOUT_CYCLES)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            wdog_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall_q && !data_bit) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        wdog_q    <= '0;
                    end
                end
                SHIFT: begin
                    if (fall_q) begin
                        sr_q      <= {data_bit, sr_q[FRAME_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        wdog_q    <= '0;
                        if (bit_cnt_q == BCNT_W'(FRAME_BITS - 1)) begin
                            state_q <= CHECK;
                        end
                    end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES)) begin
                        state_q <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                CHECK:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (err_set) begin
                frame_err_q <= 1'b1;
            end else if (err_clr) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    // A pop in the same cycle makes room, so only a full FIFO with no pop drops.
    assign fifo_drop = push && fifo_full && !(rd_en && !fifo_empty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (fifo_drop) begin
            overflow_q <= 1'b1;
        end else if (err_clr) begin
            overflow_q <= 1'b0;
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (sr_q[7:0]),
        .pop_i   (rd_en),
        .dout_o  (rx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: table-driven single frames, hand-written corner sequences
// and a randomized run checked against a queue model of the receive buffer.
module tb_ps2_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 300;
  localparam int DEPTH      = 4;
  localparam int HALF       = 20;
  // Raw stop-bit fall -> 2 sync stages + FILTER_LEN samples -> fall_edge,
  // then CHECK one cycle later and rx_valid one cycle after that.
  localparam int LAT        = FILTER_LEN + 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overflow;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic       exp_err;
  logic       exp_ovf;

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop_v;
    logic       exp_push;
  } vec_t;

  vec_t vecs[7];

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  // Sends the first nbits of a frame; on the stop bit, optionally pulses
  // rd_en pop_at cycles after the raw fall and reports when rx_valid rose.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v,
                            input int nbits, input int pop_at, output int rise);
    logic [10:0] bits;
    logic        par;
    par  = (~^d) ^ par_flip;
    bits = {stop_v, par, d, 1'b0};
    rise = -1;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(HALF);
      ps2_clk = 1'b0;
      if (i == 10) begin
        for (int k = 1; k <= HALF; k++) begin
          tick(1);
          rd_en = (k == pop_at);
          if (rise < 0 && rx_valid) rise = k;
        end
        rd_en = 1'b0;
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int r;
    send_frame(d, 1'b0, 1'b1, 11, 0, r);
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk(name, rx_data, exp);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    int         rise;
    int         w;
    int         npop;
    logic [7:0] d;
    logic       bad;

    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    tick(3);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    tick(5);

    // clean byte with latency
    send_frame(8'h1C, 1'b0, 1'b1, 11, 0, rise);
    chk("clean_latency", rise, LAT);
    chk("clean_valid", rx_valid, 1);
    chk("clean_err", frame_err, 0);
    pop_chk("clean_data", 8'h1C);
    chk("clean_empty", rx_valid, 0);

    // break sequence
    send_byte(8'hF0);
    send_byte(8'h1C);
    pop_chk("break_f0", 8'hF0);
    pop_chk("break_1c", 8'h1C);
    chk("break_empty", rx_valid, 0);

    // parity error then err_clr
    send_frame(8'h1C, 1'b1, 1'b1, 11, 0, rise);
    chk("par_valid", rx_valid, 0);
    chk("par_err", frame_err, 1);
    clear_err();
    chk("par_clr", frame_err, 0);

    // table of single frames
    vecs[0] = '{8'h00, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'hFF, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{8'hA5, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h80, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h55, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      clear_err();
      send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop_v, 11, 0, rise);
      chk($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_push);
      chk($sformatf("vec%0d_err", i), frame_err, !vecs[i].exp_push);
      if (vecs[i].exp_push) pop_chk($sformatf("vec%0d_data", i), vecs[i].data);
      else begin
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
      end
    end
    clear_err();

    // start bit of 1 is a framing error
    ps2_data = 1'b1; tick(HALF); ps2_clk = 1'b0; tick(HALF); ps2_clk = 1'b1; tick(HALF);
    chk("start_err", frame_err, 1);
    chk("start_valid", rx_valid, 0);
    clear_err();

    // overflow without pop
    for (int b = 1; b <= 5; b++) send_byte(8'(b));
    chk("ovf_valid", rx_valid, 1);
    chk("ovf_flag", overflow, 1);
    for (int b = 1; b <= 4; b++) pop_chk($sformatf("ovf_drain%0d", b), 8'(b));
    chk("ovf_empty", rx_valid, 0);
    clear_err();
    chk("ovf_clr", overflow, 0);

    // 5th push meets a pop in its CHECK cycle
    for (int b = 1; b <= 4; b++) send_byte(8'(b));
    send_frame(8'h05, 1'b0, 1'b1, 11, LAT - 1, rise);
    chk("ovfpop_flag", overflow, 0);
    for (int b = 2; b <= 5; b++) pop_chk($sformatf("ovfpop_drain%0d", b), 8'(b));
    chk("ovfpop_empty", rx_valid, 0);

    // timeout on partial frame
    send_frame(8'h29, 1'b0, 1'b1, 5, 0, rise);
    chk("to_early", frame_err, 0);
    tick(150);
    chk("to_mid", frame_err, 0);
    w = 0;
    while (!frame_err && w < 400) begin
      tick(1);
      w++;
    end
    chk("to_err", frame_err, 1);
    chk("to_valid", rx_valid, 0);
    clear_err();
    send_byte(8'h29);
    chk("to_next_err", frame_err, 0);
    pop_chk("to_next_data", 8'h29);

    // short glitch on the clock line
    ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(40);
    chk("glitch_err", frame_err, 0);
    chk("glitch_valid", rx_valid, 0);
    send_byte(8'h3C);
    pop_chk("glitch_next", 8'h3C);

    // asynchronous reset mid-frame with data buffered
    send_byte(8'h11);
    send_byte(8'h22);
    send_frame(8'h5B, 1'b1, 1'b1, 12 - 6, 0, rise);
    chk("rstmid_pre", rx_valid, 1);
    ps2_data = 1'b0; tick(HALF); ps2_clk = 1'b0; tick(4);
    #3 reset = 1'b1;
    #1;
    chk("rstmid_valid", rx_valid, 0);
    chk("rstmid_data", rx_data, 0);
    chk("rstmid_err", frame_err, 0);
    chk("rstmid_ovf", overflow, 0);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(HALF);
    send_byte(8'h5A);
    pop_chk("rstmid_next", 8'h5A);
    chk("rstmid_alone", rx_valid, 0);

    // randomized frames against the queue model
    clear_err();
    exp_err = 1'b0; exp_ovf = 1'b0;
    exp_q.delete();
    for (int it = 0; it < 24; it++) begin
      d    = 8'($urandom_range(0, 255));
      bad  = ($urandom_range(0, 4) == 0);
      npop = $urandom_range(0, 2);
      send_frame(d, bad, 1'b1, 11, 0, rise);
      if (bad) exp_err = 1'b1;
      else if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovf = 1'b1;
      chk("rnd_valid", rx_valid, exp_q.size() != 0);
      chk("rnd_err", frame_err, exp_err);
      chk("rnd_ovf", overflow, exp_ovf);
      for (int k = 0; k < npop; k++) begin
        if (exp_q.size() > 0) begin
          chk("rnd_data", rx_data, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          chk("rnd_empty", rx_valid, 0);
        end
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        clear_err();
        exp_err = 1'b0;
        exp_ovf = 1'b0;
      end
    end
    while (exp_q.size() > 0) begin
      chk("rnd_drain", rx_data, exp_q[0]);
      void'(exp_q.pop_front());
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
    end
    chk("rnd_final_empty", rx_valid, 0);

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 keyboard receiver that sits directly upstream of the AVR core's I/O bus in the avr_b3 system.
- Takes the raw PS2Clk/PS2Data board pins, then deglitches them, deframes 11-bit device-to-host frames and checks them.
- Buffers received scan codes in a small FIFO, which firmware drains through a read-strobe interface mapped to I/O registers.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronized samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 200000: clk cycles without a filtered falling edge, mid-frame, before the partial frame is aborted (2 ms at 100 MHz).
- FIFO_DEPTH, 4: scan-code buffer entries; must be a power of two.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ps2_clk  input  1  raw PS2Clk pin (asynchronous)
- ps2_data  input  1  raw PS2Data pin (asynchronous)
- rd_en  input  1  pop strobe, one cycle
- err_clr  input  1  clears the sticky error flags
- rx_data  output  8  FIFO head byte (first-word fall-through)
- rx_valid  output  1  FIFO not empty
- frame_err  output  1  sticky: start, parity, stop or timeout error seen
- overflow  output  1  sticky: a good byte was dropped because the FIFO was full

Behaviour:
- Reset values:
  - rx_data = 0x00; rx_valid = 0; frame_err = 0; overflow = 0.
  - State IDLE; FIFO empty; filter output = 1; synchronizers = 1.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clock goes 0 after FILTER_LEN consecutive synchronized 0 samples, and 1 after FILTER_LEN consecutive 1 samples.
  - A fall_edge pulse lasts one cycle, on the cycle the filtered clock goes 1->0.
  - Data is sampled from the synchronized ps2_data on the fall_edge cycle.
- Frame format: start 0, D0..D7 LSB first, odd parity, stop 1.
- State machine:
  - IDLE: on fall_edge, if data = 0 go to SHIFT with bit_cnt = 0. If data = 1, set frame_err and stay in IDLE.
  - SHIFT: each fall_edge shifts data into sr[9:0] and increments bit_cnt. After the 10th edge (D0..D7, parity, stop) go to CHECK.
  - CHECK (one cycle): good frame when ^{sr data, parity} = 1 and stop = 1.
    - Good frame: push to the FIFO.
    - Bad frame: set frame_err, no push.
    - Either way, return to IDLE.
  - Timeout: in SHIFT, a watchdog counter resets on every fall_edge. When it reaches TIMEOUT_CYCLES: set frame_err, go to IDLE, no push.
- Latency: stop-bit fall_edge in cycle N -> CHECK in N+1 -> rx_valid = 1 and rx_data valid in N+2 (when the FIFO was empty).
- FIFO behaviour:
  - rx_data always shows the head entry.
  - rd_en while rx_valid = 1 pops the head; rd_en while empty is ignored.
  - Push while full with no pop: byte dropped, overflow set, existing contents unchanged.
  - Push and pop in the same cycle:
    - Full: both occur; count unchanged; no overflow.
    - Empty: push only.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- Sticky flags: err_clr clears frame_err and overflow next cycle. A set event in the same cycle as err_clr wins (flag stays 1).
- Host-to-device transmission is not supported; ps2_clk and ps2_data are never driven.

Decomposition:
- Shared package (ps2_pkg):
  - state encoding constants: IDLE, SHIFT, CHECK
  - FRAME_BITS = 10 (bits captured after start)
  - width helper for the FIFO count
- One sub-module: ps2_fifo, a synchronous FWFT FIFO parameterized on DEPTH and WIDTH with push, pop, full, empty and overflow-drop semantics.
- The filter, synchronizers and FSM stay in ps2_rx.

Test Plan:
- Clean byte: send frame for 0x1C (parity 0), 40 us bit period -> rx_valid rises 2 cycles after the stop-bit fall_edge; rx_data = 0x1C; frame_err = 0. Pulse rd_en -> rx_valid = 0.
- Break sequence: send 0xF0 then 0x1C back-to-back without reading -> rx_data = 0xF0, then 0x1C after one rd_en, then empty after a second rd_en.
- Parity error: send 0x1C with parity 1 -> no push; rx_valid stays 0; frame_err = 1. Pulse err_clr -> frame_err = 0.
- Overflow:
  - Send 0x01..0x05 without reading -> rx_valid = 1, overflow = 1; draining yields 0x01..0x04 only.
  - Repeat with rd_en pulsed on the 5th push's CHECK cycle -> overflow = 0; drain yields 0x02..0x05.
- Timeout and glitch:
  - Send start + 4 bits then stop toggling -> frame_err = 1 after TIMEOUT_CYCLES; next clean 0x29 frame is received correctly.
  - A 3-cycle ps2_clk low glitch (shorter than FILTER_LEN) produces no fall_edge.
- Reset mid-operation: assert reset during bit 5 with 2 bytes in the FIFO -> all outputs return to reset values immediately (asynchronous); next clean 0x5A frame is received alone.
